// File: rtl/key_scan_pkg.sv
// Shared definitions for the keypad scanner: FSM states, column strobes,
// elevator key codes and small index helpers.
package key_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  localparam logic [3:0] FLOOR0    = 4'd0;
  localparam logic [3:0] FLOOR1    = 4'd1;
  localparam logic [3:0] FLOOR2    = 4'd2;
  localparam logic [3:0] FLOOR3    = 4'd3;
  localparam logic [3:0] KEY_OPEN  = 4'd4;
  localparam logic [3:0] KEY_CLOSE = 4'd5;
  localparam logic [3:0] KEY_ALARM = 4'd6;

  // Lowest-numbered low row wins when several keys share a column.
  function automatic logic [1:0] row_index(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] col);
    case (col)
      COL0:    return 2'd0;
      COL1:    return 2'd1;
      COL2:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clkin cycles.
// Shared with the multiplexed display driver.
module scan_tick_gen #(
  parameter int SCAN_DIV = 25000
) (
  input  logic clkin,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/key_scan_4x4.sv
// 4x4 keypad scanner: strobes columns, debounces press/release, emits key code.
// Build option KEY_SCAN_REPEAT_EN adds auto-repeat while a key stays held.
module key_scan_4x4
  import key_scan_pkg::*;
#(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 100
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int         DCW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  logic           tick;
  logic [3:0]     row_meta;
  logic [3:0]     row_s;
  logic [3:0]     row_lat;
  logic [3:0]     code_lat;
  logic [DCW-1:0] deb_cnt;
  logic           deb_done;
  scan_state_t    state;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clkin (clkin),
    .rst   (rst),
    .tick  (tick)
  );

  // Rows idle high, so the synchronizer resets to the released pattern.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      row_meta <= ROWS_IDLE;
      row_s    <= ROWS_IDLE;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  assign deb_done = (deb_cnt >= DCW'(DEBOUNCE_TICKS - 1));

`ifdef KEY_SCAN_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);

  logic [RCW-1:0] rep_cnt;
  logic           rep_armed;
  logic           rep_fire;

  assign rep_fire = rep_armed ? (rep_cnt >= RCW'(REPEAT_PERIOD - 1))
                              : (rep_cnt >= RCW'(REPEAT_DELAY - 1));
`else
  // Repeat timing is inert in this build; the block only keeps both parameters referenced.
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
  end
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_out   <= COL0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      deb_cnt   <= '0;
      row_lat   <= ROWS_IDLE;
      code_lat  <= '0;
`ifdef KEY_SCAN_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_s == ROWS_IDLE) begin
              col_out <= next_col(col_out);
            end else begin
              code_lat <= {row_index(row_s), col_index(col_out)};
              row_lat  <= row_s;
              deb_cnt  <= DCW'(1);
              state    <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (row_s == row_lat) begin
              deb_cnt <= deb_cnt + DCW'(1);
              if (deb_done) begin
                key_code  <= code_lat;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
`ifdef KEY_SCAN_REPEAT_EN
                rep_cnt   <= '0;
                rep_armed <= 1'b0;
`endif
              end
            end else begin
              state <= SCAN;
            end
          end
          PRESSED: begin
            if (row_s == ROWS_IDLE) begin
              deb_cnt <= DCW'(1);
              state   <= RELEASE;
            end
`ifdef KEY_SCAN_REPEAT_EN
            else if (rep_fire) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_armed <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + RCW'(1);
            end
`endif
          end
          RELEASE: begin
            if (row_s == ROWS_IDLE) begin
              deb_cnt <= deb_cnt + DCW'(1);
              if (deb_done) begin
                key_held <= 1'b0;
                col_out  <= next_col(col_out);
                state    <= SCAN;
              end
            end else begin
              state <= PRESSED;
`ifdef KEY_SCAN_REPEAT_EN
              rep_cnt   <= '0;
              rep_armed <= 1'b0;
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
